// File: rtl/jstk_spi_responder.sv
// PmodJSTK device-side model: SPI mode-0 slave serving the 5-byte
// joystick frame and capturing an optional LED command from MOSI.
`timescale 1ns/1ps
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NBYTES      = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] X_IN,
  input  logic [9:0] Y_IN,
  input  logic [2:0] BTN_IN,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_EN,
  output logic [1:0] LED_CMD,
  output logic       FRAME_DONE,
  output logic       FRAME_ABORT
);

  localparam int FW = 8 * NBYTES;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   ss_prev_q;
  logic                   sclk_prev_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   armed_q;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  state_e         state_q;
  logic [FW-1:0]  frame_q;
  logic [7:0]     tx_q;
  logic [7:0]     rx_q;
  logic [7:0]     rx_d;
  logic [3:0]     bit_q;
  logic [7:0]     byte_q;
  logic [1:0]     led_q;
  logic           done_q;
  logic           abort_q;

  logic [39:0]    map;
  logic [FW-1:0]  snap;

  // Synchronizers, edge-history flops and the post-reset arm flag.
  // armed_q only sets once a genuinely sampled SS high has been seen,
  // so an SS held low through reset cannot fake a falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      vld_q       <= '0;
      armed_q     <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_q | (vld_q[SYNC_STAGES] & ss_s);
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s & armed_q;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign rx_d      = {rx_q[6:0], mosi_s};

  assign map = {X_IN[7:0], 6'b0, X_IN[9:8],
                Y_IN[7:0], 6'b0, Y_IN[9:8],
                5'b0, BTN_IN};
  assign snap = FW'(map) << (FW - 40);

  // Frame FSM: byte 0 is loaded on the SS fall so MISO is valid in LOAD;
  // frame_q then holds the remaining bytes, consumed MSB-first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      frame_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      led_q   <= 2'b00;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            frame_q <= snap << 8;
            tx_q    <= snap[FW-1 -: 8];
            bit_q   <= '0;
            byte_q  <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (ss_rise) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end else if (sclk_rise) begin
            rx_q  <= rx_d;
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              if (byte_q == 8'd0 && rx_d[7:2] == 6'b100000)
                led_q <= rx_d[1:0];
              if (byte_q == 8'(NBYTES - 1))
                state_q <= DONE;
            end
          end else if (sclk_fall) begin
            if (bit_q == 4'd8) begin
              bit_q   <= '0;
              byte_q  <= byte_q + 8'd1;
              tx_q    <= frame_q[FW-1 -: 8];
              frame_q <= frame_q << 8;
            end else begin
              tx_q <= {tx_q[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (ss_rise) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO        = (state_q == LOAD || state_q == SHIFT) ? tx_q[7] : 1'b0;
  assign MISO_EN     = ~ss_s;
  assign LED_CMD     = led_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ABORT = abort_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: a behavioural SPI master
// checks frame bytes, LED capture, snapshot, abort, overrun and reset.
`timescale 1ns/1ps
module tb_jstk_spi_responder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] X_IN, Y_IN;
  logic [2:0] BTN_IN;
  logic       SS, SCLK, MOSI;
  logic       MISO, MISO_EN;
  logic [1:0] LED_CMD;
  logic       FRAME_DONE, FRAME_ABORT;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int d0, a0;
  bit chg_en = 1'b0;
  logic [63:0] rx;

  jstk_spi_responder #(.SYNC_STAGES(2), .NBYTES(5)) dut (
    .CLK(CLK), .RST(RST),
    .X_IN(X_IN), .Y_IN(Y_IN), .BTN_IN(BTN_IN),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .MISO_EN(MISO_EN), .LED_CMD(LED_CMD),
    .FRAME_DONE(FRAME_DONE), .FRAME_ABORT(FRAME_ABORT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (FRAME_DONE) done_cnt++;
    if (FRAME_ABORT) abort_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode-0 clocks at 10 CLK per phase; MISO sampled on each rise.
  task automatic spi_clocks(input int n, input logic [7:0] mosi0,
                            output logic [63:0] r);
    logic [7:0] m;
    m = mosi0;
    r = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = (i < 8) ? m[7-i] : 1'b0;
      #100;
      SCLK = 1'b1;
      r = {r[62:0], MISO};
      if (chg_en && i == 2) X_IN = 10'h3FF;
      #100;
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
  endtask

  task automatic spi_frame(input int n, input logic [7:0] mosi0,
                           output logic [63:0] r);
    SS = 1'b0;
    #200;
    check("miso_en", 64'(MISO_EN), 64'd1);
    spi_clocks(n, mosi0, r);
    #200;
    SS = 1'b1;
    #400;
  endtask

  initial begin
    RST = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    X_IN = 10'h2A5; Y_IN = 10'h13C; BTN_IN = 3'b101;
    #52;
    check("rst_miso", 64'(MISO), 64'd0);
    check("rst_miso_en", 64'(MISO_EN), 64'd0);
    check("rst_led", 64'(LED_CMD), 64'd0);
    check("rst_done", 64'(FRAME_DONE), 64'd0);
    check("rst_abort", 64'(FRAME_ABORT), 64'd0);
    #48;
    RST = 1'b0;
    #300;

    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(40, 8'h00, rx);
    check("nom_data", 64'(rx[39:0]), 64'hA5023C0105);
    check("nom_done", 64'(done_cnt - d0), 64'd1);
    check("nom_abort", 64'(abort_cnt - a0), 64'd0);
    check("nom_led", 64'(LED_CMD), 64'd0);

    spi_frame(40, 8'h83, rx);
    check("led_data", 64'(rx[39:0]), 64'hA5023C0105);
    check("led_set", 64'(LED_CMD), 64'd3);
    spi_frame(40, 8'h40, rx);
    check("led_keep", 64'(LED_CMD), 64'd3);

    chg_en = 1'b1;
    spi_frame(40, 8'h00, rx);
    chg_en = 1'b0;
    check("snap_cur", 64'(rx[39:0]), 64'hA5023C0105);
    spi_frame(40, 8'h00, rx);
    check("snap_next", 64'(rx[39:0]), 64'hFF033C0105);
    X_IN = 10'h2A5;

    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(13, 8'h00, rx);
    check("abort_bits", 64'(rx[12:0]), 64'h14A0);
    check("abort_pulse", 64'(abort_cnt - a0), 64'd1);
    check("abort_nodone", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt;
    spi_frame(40, 8'h00, rx);
    check("post_abort", 64'(rx[39:0]), 64'hA5023C0105);
    check("post_abort_done", 64'(done_cnt - d0), 64'd1);
    check("abort_led_kept", 64'(LED_CMD), 64'd3);

    d0 = done_cnt;
    spi_frame(48, 8'h00, rx);
    check("overrun", 64'(rx[47:0]), 64'hA5023C010500);
    check("overrun_done", 64'(done_cnt - d0), 64'd1);

    SS = 1'b0;
    #200;
    spi_clocks(18, 8'h00, rx);
    #100;
    check("pre_rst_miso", 64'(MISO), 64'd1);
    RST = 1'b1;
    #1;
    check("arst_miso", 64'(MISO), 64'd0);
    check("arst_miso_en", 64'(MISO_EN), 64'd0);
    check("arst_led", 64'(LED_CMD), 64'd0);
    #20;
    RST = 1'b0;
    #1000;
    d0 = done_cnt; a0 = abort_cnt;
    check("hold_miso_en", 64'(MISO_EN), 64'd1);
    spi_clocks(40, 8'h00, rx);
    check("hold_noframe", 64'(rx[39:0]), 64'd0);
    #200;
    SS = 1'b1;
    #400;
    check("hold_nodone", 64'(done_cnt - d0), 64'd0);
    check("hold_noabort", 64'(abort_cnt - a0), 64'd0);
    d0 = done_cnt;
    spi_frame(40, 8'h00, rx);
    check("rearm_data", 64'(rx[39:0]), 64'hA5023C0105);
    check("rearm_done", 64'(done_cnt - d0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
Name: jstk_spi_responder

Overview:
- SPI mode-0 slave that emulates the Digilent PmodJSTK on the device side of the joystick link.
- Drives MISO with the 5-byte joystick frame (X, Y, buttons) to an SPI master, such as the existing PmodJSTK reader.
- Optionally captures the master's first MOSI byte as an LED command.
- Oversamples SS/SCLK/MOSI on the 100 MHz system clock.
- Used as a board-level joystick model for simulation/loopback, and as an FPGA-to-FPGA joystick bridge.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the SS/SCLK/MOSI synchronizers (minimum 2).
- NBYTES, 5, bytes per frame; the byte map below is defined for 5.

Ports:
- CLK  in  1  system clock, 100 MHz. Single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- X_IN  in  10  joystick X position, sampled at frame start.
- Y_IN  in  10  joystick Y position, sampled at frame start.
- BTN_IN  in  3  {btn2, btn1, stick_btn}, sampled at frame start.
- SS  in  1  slave select, active low, asynchronous to CLK.
- SCLK  in  1  serial clock from master, idle low, asynchronous to CLK.
- MOSI  in  1  master out slave in; may be tied to 0.
- MISO  out  1  serial data to master, MSB first.
- MISO_EN  out  1  high while SS is asserted; board-level tri-state enable.
- LED_CMD  out  2  last valid LED command {led2, led1}.
- FRAME_DONE  out  1  one-CLK pulse after a complete frame.
- FRAME_ABORT  out  1  one-CLK pulse when SS deasserts mid-frame.

Behaviour:
- Synchronizers and edge detection:
  - SS, SCLK and MOSI each pass through SYNC_STAGES flip-flops before use.
  - Edge detect compares the last synchronizer stage with one extra delayed copy.
  - All events below are expressed in synchronized time.
- Timing requirement on the master: SCLK high and low phases ≥ SYNC_STAGES+3 CLK each; SS-fall to first SCLK rise ≥ SYNC_STAGES+3 CLK. The 66.67 kHz master satisfies this by >100x.
- Frame byte map, byte 0 first:
  - B0 = X[7:0]
  - B1 = {6'b0, X[9:8]}
  - B2 = Y[7:0]
  - B3 = {6'b0, Y[9:8]}
  - B4 = {5'b0, BTN[2:0]}
- States:
  - IDLE -> LOAD on SS falling edge.
  - LOAD, one cycle: snapshot X/Y/BTN into a 40-bit frame register, load tx shift with B0, bit_cnt=0, byte_cnt=0 -> SHIFT.
  - SHIFT:
    - SCLK rising: sample MOSI into rx shift; bit_cnt++.
    - SCLK falling: shift tx left; MISO = next bit.
    - At the falling edge following the 8th rising edge of a byte: bit_cnt=0, byte_cnt++, load the next byte into the tx shift.
    - After the 8th rising edge of byte NBYTES-1 -> DONE.
    - SS rising in SHIFT -> IDLE with FRAME_ABORT=1 for one cycle.
  - DONE:
    - Extra SCLK edges shift out 0s, with no byte/bit counting and no wrap-around.
    - SS rising -> IDLE with FRAME_DONE=1 for one cycle.
- MISO:
  - MISO = tx_shift[7] in LOAD/SHIFT; 0 in IDLE/DONE.
  - First bit (B0[7]) is valid 1 CLK after the SS fall is detected, i.e. before the first SCLK rise.
- LED command:
  - Captured when rx byte 0 completes (8th rising edge of byte 0).
  - If rx[7:2] == 6'b100000, LED_CMD <= rx[1:0] immediately; otherwise LED_CMD is unchanged.
  - A captured command stays even if the frame later aborts.
- Input timing: X/Y/BTN changes during a frame do not affect the current frame; they take effect next frame.
- Simultaneous SCLK and SS edges in the same CLK: the SS edge wins.
  - SS rising: the SCLK edge is ignored.
  - SS falling from IDLE: the SCLK edge is ignored.
- Reset, asynchronous and effective at any time, including mid-frame:
  - state=IDLE, MISO=0, MISO_EN=0, LED_CMD=2'b00, FRAME_DONE=0, FRAME_ABORT=0.
  - Counters, shift registers and synchronizer flops are cleared; synchronizers reset to the idle levels SS=1, SCLK=0.
  - After reset deasserts, an SS already low does not start a frame until SS is seen high, then falls.
- MISO_EN equals the inverted synchronized SS.

Test Plan:
- Nominal frame: X=10'h2A5, Y=10'h13C, BTN=3'b101, master runs 40 SCLK at 66.67 kHz, MOSI=0 -> master receives bytes A5 02 3C 01 05 (40'hA5023C0105). FRAME_DONE pulses once after SS rises. LED_CMD stays 00.
- LED command: MOSI byte 0 = 8'h83 -> LED_CMD=2'b11 after the 8th SCLK rise. Next frame with byte 0 = 8'h40 -> LED_CMD remains 2'b11.
- Snapshot: change X to 10'h3FF after the 3rd SCLK rise -> current frame still carries A5 02. The following frame carries FF 03.
- Abort: SS rises after 13 SCLK rises -> FRAME_ABORT pulses once, FRAME_DONE stays 0. The next full frame returns a correct 40'hA5023C0105.
- Overrun: 48 SCLK in one SS window -> first 40 bits correct, last 8 bits 0. FRAME_DONE pulses once.
- Async reset: RST pulsed mid byte 2 -> MISO=0, MISO_EN=0, LED_CMD=00 in the same cycle. Holding SS low after reset produces no frame until SS toggles high then low.
